// File: rtl/bus_cycle_ctrl.sv
// 8088 local-bus controller: latches the multiplexed address on ALE, decodes it into
// one-hot chip selects, and stretches READY by a per-region wait-state count.
module bus_cycle_ctrl #(
  parameter int ADDR_W = 20,
  parameter int NUM_CS = 4,
  parameter int WAIT_W = 4,
  parameter logic [NUM_CS*ADDR_W-1:0] CS_BASE = '0,
  parameter logic [NUM_CS*ADDR_W-1:0] CS_MASK = '0,
  parameter logic [NUM_CS-1:0]        CS_IO   = '0,
  parameter logic [NUM_CS*WAIT_W-1:0] CS_WAIT = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              ALE,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic              IOM,
  input  logic              RD,
  input  logic              WR,
  output logic [ADDR_W-1:0] Address,
  output logic [NUM_CS-1:0] CS,
  output logic              READY,
  output logic              DEC_ERR,
  output logic              PROT_ERR,
  output logic              BUSY,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ADDR   = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  logic [1:0]        state, nxt_state;
  logic [WAIT_W-1:0] cnt, nxt_cnt;
  logic [NUM_CS-1:0] nxt_cs;
  logic              nxt_ready, nxt_dec, nxt_prot;

  logic [NUM_CS-1:0] hit_vec;
  logic              hit_any;
  logic [WAIT_W-1:0] hit_wait;

  logic strobe_one, strobe_both, strobe_none;

  assign strobe_one  = RD ^ WR;
  assign strobe_both = ~RD & ~WR;
  assign strobe_none = RD & WR;
  assign fsm_state   = state;

  // Scan from the top down so the lowest-indexed matching region is the one kept.
  always_comb begin
    hit_vec  = '0;
    hit_any  = 1'b0;
    hit_wait = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (((Address & CS_MASK[i*ADDR_W +: ADDR_W]) ==
           (CS_BASE[i*ADDR_W +: ADDR_W] & CS_MASK[i*ADDR_W +: ADDR_W])) &&
          (IOM == CS_IO[i])) begin
        hit_vec    = '0;
        hit_vec[i] = 1'b1;
        hit_any    = 1'b1;
        hit_wait   = CS_WAIT[i*WAIT_W +: WAIT_W];
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_cs    = CS;
    nxt_ready = READY;
    nxt_cnt   = cnt;
    nxt_dec   = 1'b0;
    nxt_prot  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ALE) nxt_state = S_ADDR;
        else if (!strobe_none) nxt_prot = 1'b1;
      end
      S_ADDR: begin
        // A second ALE before any strobe simply restarts the cycle on the new address.
        if (!ALE) begin
          if (strobe_both) begin
            nxt_prot  = 1'b1;
            nxt_cs    = '0;
            nxt_state = S_IDLE;
          end else if (strobe_one) begin
            if (hit_any) begin
              nxt_cs  = hit_vec;
              nxt_cnt = hit_wait;
              if (hit_wait == '0) begin
                nxt_ready = 1'b1;
                nxt_state = S_ACTIVE;
              end else begin
                nxt_ready = 1'b0;
                nxt_state = S_WAIT;
              end
            end else begin
              nxt_dec   = 1'b1;
              nxt_cs    = '0;
              nxt_ready = 1'b1;
              nxt_state = S_ACTIVE;
            end
          end
        end
      end
      S_WAIT: begin
        if (strobe_none) begin
          nxt_cs    = '0;
          nxt_ready = 1'b1;
          nxt_cnt   = '0;
          nxt_state = S_IDLE;
        end else begin
          nxt_cnt = cnt - 1'b1;
          if (cnt == 1) begin
            nxt_ready = 1'b1;
            nxt_state = S_ACTIVE;
          end else begin
            nxt_ready = 1'b0;
          end
        end
      end
      default: begin
        if (strobe_none) begin
          nxt_cs    = '0;
          nxt_ready = 1'b1;
          nxt_state = ALE ? S_ADDR : S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      CS       <= '0;
      READY    <= 1'b1;
      DEC_ERR  <= 1'b0;
      PROT_ERR <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= nxt_state;
      cnt      <= nxt_cnt;
      CS       <= nxt_cs;
      READY    <= nxt_ready;
      DEC_ERR  <= nxt_dec;
      PROT_ERR <= nxt_prot;
      BUSY     <= (nxt_state != S_IDLE);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) Address <= '0;
    else if (ALE) Address <= ADDR_IN;
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Directed bench for bus_cycle_ctrl: transaction tasks derive the per-cycle expected
// outputs from the region tables and feed a queue checked once per clock.
module tb_bus_cycle_ctrl;

  localparam int AW = 20;
  localparam int NC = 4;
  localparam int WW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          ALE = 1'b0;
  logic [AW-1:0] ADDR_IN = '0;
  logic          IOM = 1'b0;
  logic          RD = 1'b1;
  logic          WR = 1'b1;
  logic [AW-1:0] Address;
  logic [NC-1:0] CS;
  logic          READY, DEC_ERR, PROT_ERR, BUSY;
  logic [1:0]    fsm_state;

  bus_cycle_ctrl #(
    .ADDR_W (AW),
    .NUM_CS (NC),
    .WAIT_W (WW),
    .CS_BASE({20'h00000, 20'h0FF00, 20'h01C00, 20'h80000}),
    .CS_MASK({20'hF0000, 20'h0FFF0, 20'hFFF00, 20'h80000}),
    .CS_IO  (4'b0100),
    .CS_WAIT({4'd2, 4'd3, 4'd1, 4'd0})
  ) dut (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .ADDR_IN(ADDR_IN), .IOM(IOM),
    .RD(RD), .WR(WR), .Address(Address), .CS(CS), .READY(READY),
    .DEC_ERR(DEC_ERR), .PROT_ERR(PROT_ERR), .BUSY(BUSY), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // region tables as the bench sees them
  logic [AW-1:0] base_t [NC] = '{20'h80000, 20'h01C00, 20'h0FF00, 20'h00000};
  logic [AW-1:0] mask_t [NC] = '{20'h80000, 20'hFFF00, 20'h0FFF0, 20'hF0000};
  logic          io_t   [NC] = '{1'b0, 1'b0, 1'b1, 1'b0};
  int            wait_t [NC] = '{0, 1, 3, 2};

  // scoreboard
  logic [27:0]   exp_q [$];
  logic [AW-1:0] m_addr = '0;
  int            n_checks = 0;
  int            n_fail = 0;
  int            ready_run = 0;
  int            last_run = 0;

  function automatic int model_region(input logic [AW-1:0] a, input logic iom);
    for (int i = 0; i < NC; i++)
      if ((a & mask_t[i]) == (base_t[i] & mask_t[i]) && iom == io_t[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // one clock of stimulus plus the outputs required after that edge
  task automatic step(input logic ale, input logic [AW-1:0] ain, input logic iom,
                      input logic rd, input logic wr, input logic [NC-1:0] e_cs,
                      input logic e_rdy, input logic e_dec, input logic e_prot,
                      input logic e_busy);
    ALE = ale; ADDR_IN = ain; IOM = iom; RD = rd; WR = wr;
    if (ale) m_addr = ain;
    @(posedge CLK); #1;
    exp_q.push_back({m_addr, e_cs, e_rdy, e_dec, e_prot, e_busy});
  endtask

  // complete bus cycle: ALE, strobe, wait states, hold, release (optionally with a new ALE)
  task automatic bus_cycle(input logic [AW-1:0] a, input logic iom, input logic is_wr,
                           input int hold, input logic rel_ale, input logic [AW-1:0] next_a);
    int r, w;
    logic [NC-1:0] csv;
    logic rd, wr;
    r   = model_region(a, iom);
    w   = (r >= 0) ? wait_t[r] : 0;
    csv = (r >= 0) ? NC'(1 << r) : '0;
    rd  = is_wr;
    wr  = ~is_wr;
    step(1'b1, a, iom, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, a, iom, rd, wr, csv, (w == 0), (r < 0), 1'b0, 1'b1);
    for (int j = 1; j <= w; j++)
      step(1'b0, a, iom, rd, wr, csv, (j == w), 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < hold; j++)
      step(1'b0, a, iom, rd, wr, csv, 1'b1, 1'b0, 1'b0, 1'b1);
    step(rel_ale, next_a, iom, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, rel_ale);
  endtask

  // compare process: one expected vector per clock, sampled mid-cycle
  initial begin
    logic [27:0] e, got;
    forever begin
      @(negedge CLK);
      if (READY === 1'b0) ready_run++;
      else if (ready_run > 0) begin last_run = ready_run; ready_run = 0; end
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {Address, CS, READY, DEC_ERR, PROT_ERR, BUSY};
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL cycle_cmp @%0t: addr=%h cs=%b rdy=%b dec=%b prot=%b busy=%b, expected addr=%h cs=%b rdy=%b dec=%b prot=%b busy=%b",
                   $time, got[27:8], got[7:4], got[3], got[2], got[1], got[0],
                   e[27:8], e[7:4], e[3], e[2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // model pins
    check("model_r0", model_region(20'h81234, 1'b0), 0);
    check("model_r2", model_region(20'h0FF05, 1'b1), 2);
    check("model_overlap", model_region(20'h01C10, 1'b0), 1);
    check("model_none", model_region(20'h7F000, 1'b0), 32'hFFFFFFFF);

    repeat (3) @(posedge CLK);
    #1;
    check("rst_addr", Address, 0);
    check("rst_cs", CS, 0);
    check("rst_ready", READY, 1);
    check("rst_busy", BUSY, 0);
    RESET = 1'b0;

    // zero-wait memory read
    bus_cycle(20'h81234, 1'b0, 1'b0, 1, 1'b0, '0);
    check("t2_addr", Address, 20'h81234);

    // I/O read with three wait states
    bus_cycle(20'h0FF05, 1'b1, 1'b0, 0, 1'b0, '0);
    check("t3_ready_low_run", last_run, 3);

    // overlapping regions 1 and 3: lowest index wins
    step(1'b1, 20'h01C10, 1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 20'h01C10, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t4_cs", CS, 4'b0010);
    step(1'b0, 20'h01C10, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 20'h01C10, 1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_cycle(20'h05000, 1'b0, 1'b1, 1, 1'b0, '0);

    // unmapped write
    bus_cycle(20'h7F000, 1'b0, 1'b1, 1, 1'b0, '0);
    check("t5_idle", fsm_state, 0);

    // both strobes low, then a normal cycle
    step(1'b1, 20'h12345, 1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 20'h12345, 1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 20'h12345, 1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    bus_cycle(20'h8ABCD, 1'b0, 1'b0, 0, 1'b0, '0);

    // strobe with no ALE-latched cycle
    step(1'b0, 20'h8ABCD, 1'b0, 1'b0, 1'b1, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 20'h8ABCD, 1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // aborted cycle: second ALE before any strobe
    step(1'b1, 20'h11111, 1'b0, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    bus_cycle(20'h8F000, 1'b0, 1'b0, 0, 1'b0, '0);

    // back-to-back: ALE on the release edge
    bus_cycle(20'h0FF08, 1'b1, 1'b0, 0, 1'b1, 20'h01C20);
    bus_cycle(20'h01C20, 1'b0, 1'b0, 0, 1'b0, '0);

    // strobe released during wait states
    step(1'b1, 20'h0FF0A, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 20'h0FF0A, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 20'h0FF0A, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 20'h0FF0A, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0);

    // asynchronous reset while waiting with cnt=3
    step(1'b1, 20'h0FF05, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 20'h0FF05, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK); #1;
    RESET = 1'b1;
    #1;
    check("t1_cs", CS, 0);
    check("t1_ready", READY, 1);
    check("t1_busy", BUSY, 0);
    check("t1_addr", Address, 0);
    m_addr = '0;
    step(1'b0, 20'h0FF05, 1'b1, 1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    bus_cycle(20'h81234, 1'b0, 1'b0, 0, 1'b0, '0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL queue_drain: %0d expected vectors left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
